// File: rtl/fsm_experiment_multi_trigger_pkg.sv
// Shared types for the multi-trigger experiment sequencer: sizes, state codes
// and the run-parameter bundle latched at run start.
package fsm_experiment_multi_trigger_pkg;

    localparam int unsigned MT_CNT_W  = 32;
    localparam int unsigned MT_N_TRIG = 4;
    localparam int unsigned MT_SHOT_W = 4;

    // Externally visible scenario_state codes
    typedef enum logic [7:0] {
        ST_IDLE       = 8'h00,
        ST_WAIT_FG    = 8'h01,
        ST_FG_DELAY   = 8'h02,
        ST_WAIT_READY = 8'h03,
        ST_WAIT_PHASE = 8'h04,
        ST_SHIFT      = 8'h05,
        ST_FIRE       = 8'h06,
        ST_DONE       = 8'h07,
        ST_ABORT      = 8'hFE,
        ST_ERROR      = 8'hFF
    } state_e;

    // Per-channel trigger sequencing
    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_DELAY = 2'd1,
        CH_PULSE = 2'd2,
        CH_DONE  = 2'd3
    } ch_state_e;

    typedef struct packed {
        logic [MT_CNT_W-1:0]                    fg_open_delay;
        logic [MT_CNT_W-1:0]                    detector_ready_timeout;
        logic [MT_CNT_W-1:0]                    phase_shift;
        logic [MT_CNT_W-1:0]                    detonate_len;
        logic [MT_SHOT_W-1:0]                   shots;
        logic [MT_N_TRIG-1:0][MT_CNT_W-1:0]     trig_delay;
        logic [MT_N_TRIG-1:0][MT_CNT_W-1:0]     trig_len;
    } parameters_mt_t;

endpackage

// File: rtl/fsm_experiment_multi_trigger_if.sv
// Sensor inputs, run parameters and pulse/status outputs of the sequencer.
interface fsm_experiment_multi_trigger_if;
    import fsm_experiment_multi_trigger_pkg::*;

    logic                   start;
    logic                   fg_opto;
    logic                   phase;
    logic                   wire_sensor;
    logic                   detector_ready;
    logic                   abort;
    parameters_mt_t         par;

    logic                   detonator_triggered;
    logic [MT_N_TRIG-1:0]   trigger;
    logic [7:0]             scenario_state;
    logic [MT_SHOT_W-1:0]   shot_index;
    logic                   wire_ok;
    logic                   busy;

    modport master (
        output start, fg_opto, phase, wire_sensor, detector_ready, abort, par,
        input  detonator_triggered, trigger, scenario_state, shot_index, wire_ok, busy
    );

    modport slave (
        input  start, fg_opto, phase, wire_sensor, detector_ready, abort, par,
        output detonator_triggered, trigger, scenario_state, shot_index, wire_ok, busy
    );

endinterface

// File: rtl/fsm_experiment_multi_trigger_trigger_channel.sv
// One trigger output: after arm, waits delay_i cycles then pulses for len_i
// cycles; done_o rises once the pulse (or a zero-length slot) has finished.
module fsm_experiment_multi_trigger_trigger_channel
    import fsm_experiment_multi_trigger_pkg::*;
#(
    parameter int unsigned CNT_W = MT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             pulse_o,
    output logic             done_o
);

    ch_state_e        ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             done_q, done_d;

    // Channel state and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q    <= CH_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    // Next state: cnt_q is the cycle index while delaying, pulse length while pulsing
    always_comb begin
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (ch_q)
            CH_IDLE, CH_DONE: begin
            end
            CH_DELAY: begin
                if (cnt_q == delay_i - CNT_W'(1)) begin
                    if (len_i == '0) begin
                        ch_d = CH_DONE;
                    end else begin
                        ch_d    = CH_PULSE;
                        cnt_d   = CNT_W'(1);
                        pulse_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CH_PULSE: begin
                if (cnt_q == len_i) begin
                    ch_d = CH_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    pulse_d = 1'b1;
                end
            end
            default: ch_d = CH_IDLE;
        endcase
        if (arm_i) begin
            cnt_d = '0;
            if (delay_i != '0) begin
                ch_d = CH_DELAY;
            end else if (len_i != '0) begin
                ch_d    = CH_PULSE;
                cnt_d   = CNT_W'(1);
                pulse_d = 1'b1;
            end else begin
                ch_d = CH_DONE;
            end
        end
        if (clr_i) begin
            ch_d    = CH_IDLE;
            cnt_d   = '0;
            pulse_d = 1'b0;
        end
        done_d = (ch_d == CH_DONE);
    end

    assign pulse_o = pulse_q;
    assign done_o  = done_q;

endmodule

// File: rtl/fsm_experiment_multi_trigger.sv
// Experiment-phase sequencer: start, fast-gate, gate delay, detector-ready
// wait with timeout, phase alignment and shift, then fire of a detonator pulse
// plus N_TRIG delayed trigger pulses, repeated for a configurable shot count.
module fsm_experiment_multi_trigger
    import fsm_experiment_multi_trigger_pkg::*;
#(
    parameter int unsigned CNT_W  = MT_CNT_W,
    parameter int unsigned N_TRIG = MT_N_TRIG,
    parameter int unsigned SHOT_W = MT_SHOT_W
) (
    input logic                          clock,
    input logic                          reset_signal,
    fsm_experiment_multi_trigger_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SHOT_W-1:0] shot_q, shot_d;
    logic             det_q, det_d;
    logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
    logic             wire_ok_q, wire_ok_d;
    logic             busy_q, busy_d;
    parameters_mt_t   shadow_q, shadow_d;
    logic             start_q, fg_q, phase_q;

    logic             start_rise_c, fg_rise_c, phase_rise_c;
    logic             abort_take_c, fire_done_c;
    logic             arm_c, clr_c;
    logic [SHOT_W:0]  shot_nxt_c, shots_eff_c;
    logic [N_TRIG-1:0] ch_pulse, ch_done;

    assign start_rise_c = bus.start   & ~start_q;
    assign fg_rise_c    = bus.fg_opto & ~fg_q;
    assign phase_rise_c = bus.phase   & ~phase_q;
    assign abort_take_c = bus.abort && !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign fire_done_c  = !det_q && (&ch_done);
    assign shot_nxt_c   = {1'b0, shot_q} + (SHOT_W+1)'(1);
    assign shots_eff_c  = (shadow_q.shots == '0) ? (SHOT_W+1)'(1) : {1'b0, shadow_q.shots};

    // Sequencer and datapath registers
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shot_q    <= '0;
            det_q     <= 1'b0;
            det_cnt_q <= '0;
            wire_ok_q <= 1'b0;
            busy_q    <= 1'b0;
            shadow_q  <= '0;
            start_q   <= 1'b0;
            fg_q      <= 1'b0;
            phase_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shot_q    <= shot_d;
            det_q     <= det_d;
            det_cnt_q <= det_cnt_d;
            wire_ok_q <= wire_ok_d;
            busy_q    <= busy_d;
            shadow_q  <= shadow_d;
            start_q   <= bus.start;
            fg_q      <= bus.fg_opto;
            phase_q   <= bus.phase;
        end
    end

    // Next state, detonator pulse, wire status and channel arm/clear
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shot_d    = shot_q;
        det_d     = det_q;
        det_cnt_d = det_cnt_q;
        wire_ok_d = wire_ok_q;
        shadow_d  = shadow_q;
        arm_c     = 1'b0;
        clr_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_rise_c) begin
                    state_d  = ST_WAIT_FG;
                    shot_d   = '0;
                    shadow_d = bus.par;
                end
            end
            ST_WAIT_FG: begin
                if (fg_rise_c) state_d = ST_FG_DELAY;
            end
            ST_FG_DELAY: begin
                if (cnt_q == shadow_q.fg_open_delay) state_d = ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
                // Timeout outranks a simultaneous ready
                if (cnt_q == shadow_q.detector_ready_timeout) state_d = ST_ERROR;
                else if (bus.detector_ready)                 state_d = ST_WAIT_PHASE;
            end
            ST_WAIT_PHASE: begin
                if (phase_rise_c) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == shadow_q.phase_shift) state_d = ST_FIRE;
            end
            ST_FIRE: begin
                if (fire_done_c) begin
                    shot_d  = shot_nxt_c[SHOT_W-1:0];
                    state_d = (shot_nxt_c < shots_eff_c) ? ST_WAIT_READY : ST_DONE;
                end
            end
            ST_DONE, ST_ABORT, ST_ERROR: begin
                if (!bus.start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_take_c) begin
            state_d = ST_ABORT;
            shot_d  = shot_q;
        end

        // Detonator runs for detonate_len cycles counted from 1
        if (state_q == ST_FIRE && det_q) begin
            if (det_cnt_q == shadow_q.detonate_len) det_d = 1'b0;
            else                                    det_cnt_d = det_cnt_q + CNT_W'(1);
        end

        if (state_d == ST_FIRE && state_q != ST_FIRE) begin
            arm_c     = 1'b1;
            det_d     = (shadow_q.detonate_len != '0);
            det_cnt_d = CNT_W'(1);
            wire_ok_d = 1'b0;
        end else if (state_q == ST_FIRE && bus.wire_sensor) begin
            wire_ok_d = 1'b1;
        end

        if (abort_take_c) begin
            det_d = 1'b0;
            clr_c = 1'b1;
        end

        // State counter restarts on every state change and saturates
        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);

        busy_d = (state_d != ST_IDLE);
    end

    for (genvar gi = 0; gi < N_TRIG; gi++) begin : g_ch
        fsm_experiment_multi_trigger_trigger_channel #(.CNT_W(CNT_W)) u_ch (
            .clk     (clock),
            .rst     (reset_signal),
            .arm_i   (arm_c),
            .clr_i   (clr_c),
            .delay_i (shadow_q.trig_delay[gi]),
            .len_i   (shadow_q.trig_len[gi]),
            .pulse_o (ch_pulse[gi]),
            .done_o  (ch_done[gi])
        );
    end

    assign bus.detonator_triggered = det_q;
    assign bus.trigger             = ch_pulse;
    assign bus.scenario_state      = state_q;
    assign bus.shot_index          = shot_q;
    assign bus.wire_ok             = wire_ok_q;
    assign bus.busy                = busy_q;

endmodule

// File: tb/tb_fsm_experiment_multi_trigger.sv
// Directed bench for the multi-trigger experiment sequencer.
module tb_fsm_experiment_multi_trigger;
    import fsm_experiment_multi_trigger_pkg::*;

    logic clock;
    logic reset_signal;
    fsm_experiment_multi_trigger_if bus ();

    fsm_experiment_multi_trigger dut (
        .clock        (clock),
        .reset_signal (reset_signal),
        .bus          (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec;
    int n_err;
    int n;
    int fire_n, det_first, det_n;
    logic wok0;
    int tr_first [4];
    int tr_n     [4];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_par(input int unsigned fd, to, ps, dl, sh,
                           input int unsigned d0, d1, d2, d3,
                           input int unsigned l0, l1, l2, l3);
        bus.par.fg_open_delay          = fd;
        bus.par.detector_ready_timeout = to;
        bus.par.phase_shift            = ps;
        bus.par.detonate_len           = dl;
        bus.par.shots                  = MT_SHOT_W'(sh);
        bus.par.trig_delay[0] = d0; bus.par.trig_delay[1] = d1;
        bus.par.trig_delay[2] = d2; bus.par.trig_delay[3] = d3;
        bus.par.trig_len[0]   = l0; bus.par.trig_len[1]   = l1;
        bus.par.trig_len[2]   = l2; bus.par.trig_len[3]   = l3;
    endtask

    // Steps while the state holds; n = cycles spent in it (bounded)
    task automatic count_state(input logic [7:0] code, input int budget, output int cnt);
        cnt = 0;
        while (bus.scenario_state == code && cnt < budget) begin
            step();
            cnt++;
        end
    endtask

    // Start from IDLE, raise fg_opto, land in FG_DELAY
    task automatic start_run(input string tag);
        bus.start = 1'b1;
        step();
        chk({tag, "_wait_fg"}, 32'(bus.scenario_state), 32'h01);
        chk({tag, "_shot_clr"}, 32'(bus.shot_index), 0);
        bus.fg_opto = 1'b1;
        step();
        chk({tag, "_fg_delay"}, 32'(bus.scenario_state), 32'h02);
    endtask

    task automatic end_run();
        bus.start   = 1'b0;
        bus.fg_opto = 1'b0;
        bus.phase   = 1'b0;
        step();
    endtask

    // Records pulse timing per FIRE cycle index; optional wire pulse at wire_k
    task automatic observe_fire(input int wire_k);
        fire_n    = 0;
        det_first = -1;
        det_n     = 0;
        wok0      = bus.wire_ok;
        for (int i = 0; i < 4; i++) begin
            tr_first[i] = -1;
            tr_n[i]     = 0;
        end
        while (bus.scenario_state == 8'h06 && fire_n < 2000) begin
            if (bus.detonator_triggered) begin
                if (det_first < 0) det_first = fire_n;
                det_n++;
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.trigger[i[1:0]]) begin
                    if (tr_first[i[1:0]] < 0) tr_first[i[1:0]] = fire_n;
                    tr_n[i[1:0]]++;
                end
            end
            bus.wire_sensor = (fire_n == wire_k);
            step();
            fire_n++;
        end
        bus.wire_sensor = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.start = 0; bus.fg_opto = 0; bus.phase = 0; bus.wire_sensor = 0;
        bus.detector_ready = 0; bus.abort = 0;
        bus.par = '0;
        reset_signal = 1'b1;
        step();
        step();
        chk("rst_state", 32'(bus.scenario_state), 0);
        chk("rst_det",   32'(bus.detonator_triggered), 0);
        chk("rst_trig",  32'(bus.trigger), 0);
        chk("rst_shot",  32'(bus.shot_index), 0);
        chk("rst_wok",   32'(bus.wire_ok), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        reset_signal = 1'b0;
        bus.abort = 1'b1;
        step();
        chk("idle_abort_ignored", 32'(bus.scenario_state), 0);
        bus.abort = 1'b0;

        // Nominal single shot
        set_par(20, 1000, 13, 20, 1, 0, 10, 100, 300, 20, 20, 20, 20);
        bus.detector_ready = 1'b1;
        bus.start = 1'b1;
        step();
        chk("nom_wait_fg", 32'(bus.scenario_state), 32'h01);
        chk("nom_busy",    32'(bus.busy), 1);
        bus.par.fg_open_delay = 5;
        step();
        step();
        chk("nom_wait_fg_hold", 32'(bus.scenario_state), 32'h01);
        bus.fg_opto = 1'b1;
        step();
        chk("nom_fg_delay", 32'(bus.scenario_state), 32'h02);
        count_state(8'h02, 100, n);
        chk("nom_fg_delay_len", n, 21);
        chk("nom_wait_ready", 32'(bus.scenario_state), 32'h03);
        count_state(8'h03, 100, n);
        chk("nom_ready_len", n, 1);
        step();
        step();
        chk("nom_wait_phase", 32'(bus.scenario_state), 32'h04);
        bus.phase = 1'b1;
        step();
        chk("nom_shift", 32'(bus.scenario_state), 32'h05);
        count_state(8'h05, 100, n);
        chk("nom_shift_len", n, 14);
        chk("nom_fire", 32'(bus.scenario_state), 32'h06);
        observe_fire(-1);
        chk("nom_fire_len",  fire_n, 321);
        chk("nom_det_first", det_first, 0);
        chk("nom_det_len",   det_n, 20);
        chk("nom_t0_first",  tr_first[0], 0);
        chk("nom_t1_first",  tr_first[1], 10);
        chk("nom_t2_first",  tr_first[2], 100);
        chk("nom_t3_first",  tr_first[3], 300);
        chk("nom_t3_len",    tr_n[3], 20);
        chk("nom_done",      32'(bus.scenario_state), 32'h07);
        chk("nom_shot",      32'(bus.shot_index), 1);
        chk("nom_wire_ok",   32'(bus.wire_ok), 0);
        step();
        chk("nom_done_hold", 32'(bus.scenario_state), 32'h07);
        end_run();
        chk("nom_idle", 32'(bus.scenario_state), 0);
        chk("nom_idle_busy", 32'(bus.busy), 0);

        // Detector-ready timeout
        set_par(0, 50, 0, 10, 1, 0, 0, 0, 0, 5, 5, 5, 5);
        bus.detector_ready = 1'b0;
        start_run("to");
        count_state(8'h02, 100, n);
        chk("to_fg_len", n, 1);
        count_state(8'h03, 200, n);
        chk("to_ready_len", n, 51);
        chk("to_error", 32'(bus.scenario_state), 32'hFF);
        chk("to_det",   32'(bus.detonator_triggered), 0);
        chk("to_trig",  32'(bus.trigger), 0);
        bus.abort = 1'b1;
        step();
        chk("to_sticky_abort", 32'(bus.scenario_state), 32'hFF);
        bus.abort = 1'b0;
        end_run();
        chk("to_idle", 32'(bus.scenario_state), 0);

        // Zero timeout outranks a ready detector
        set_par(0, 0, 0, 10, 1, 0, 0, 0, 0, 5, 5, 5, 5);
        bus.detector_ready = 1'b1;
        start_run("to0");
        step();
        count_state(8'h03, 100, n);
        chk("to0_ready_len", n, 1);
        chk("to0_error", 32'(bus.scenario_state), 32'hFF);
        end_run();

        // Abort 50 cycles into FIRE
        set_par(0, 1000, 0, 100, 1, 0, 0, 0, 0, 100, 100, 100, 100);
        start_run("ab");
        step();
        step();
        chk("ab_wait_phase", 32'(bus.scenario_state), 32'h04);
        bus.phase = 1'b1;
        step();
        count_state(8'h05, 100, n);
        chk("ab_shift_len", n, 1);
        repeat (50) step();
        chk("ab_fire_mid",  32'(bus.scenario_state), 32'h06);
        chk("ab_det_mid",   32'(bus.detonator_triggered), 1);
        chk("ab_trig_mid",  32'(bus.trigger), 32'hF);
        bus.abort = 1'b1;
        step();
        chk("ab_state", 32'(bus.scenario_state), 32'hFE);
        chk("ab_det",   32'(bus.detonator_triggered), 0);
        chk("ab_trig",  32'(bus.trigger), 0);
        chk("ab_busy",  32'(bus.busy), 1);
        bus.abort = 1'b0;
        step();
        chk("ab_hold", 32'(bus.scenario_state), 32'hFE);
        end_run();
        chk("ab_idle", 32'(bus.scenario_state), 0);

        // Three shots, wire sensor in shots 2 and 3
        set_par(0, 1000, 2, 5, 3, 0, 1, 2, 3, 2, 2, 2, 2);
        start_run("ms");
        step();
        step();
        for (int s = 0; s < 3; s++) begin
            chk("ms_wait_phase", 32'(bus.scenario_state), 32'h04);
            if (s > 0) begin
                repeat (4) step();
                chk("ms_no_phase_rise", 32'(bus.scenario_state), 32'h04);
            end
            bus.phase = 1'b0;
            step();
            bus.phase = 1'b1;
            step();
            count_state(8'h05, 100, n);
            chk("ms_shift_len", n, 3);
            observe_fire((s == 0) ? -1 : s + 1);
            chk("ms_fire_len", fire_n, 6);
            chk("ms_det_len",  det_n, 5);
            chk("ms_shot",     32'(bus.shot_index), s + 1);
            chk("ms_wire_ok",  32'(bus.wire_ok), (s == 0) ? 0 : 1);
            if (s == 2) chk("ms_wire_clr_entry", 32'(wok0), 0);
            if (s < 2) begin
                chk("ms_wait_ready", 32'(bus.scenario_state), 32'h03);
                step();
            end
        end
        chk("ms_done", 32'(bus.scenario_state), 32'h07);
        step();
        chk("ms_wire_hold", 32'(bus.wire_ok), 1);
        end_run();

        // Zero-valued delays, lengths and shot count
        set_par(0, 1000, 0, 0, 0, 0, 3, 5, 0, 4, 4, 0, 2);
        start_run("zv");
        count_state(8'h02, 100, n);
        chk("zv_fg_len", n, 1);
        step();
        bus.phase = 1'b1;
        step();
        count_state(8'h05, 100, n);
        chk("zv_shift_len", n, 1);
        observe_fire(-1);
        chk("zv_fire_len", fire_n, 8);
        chk("zv_det_len",  det_n, 0);
        chk("zv_t1_first", tr_first[1], 3);
        chk("zv_t2_len",   tr_n[2], 0);
        chk("zv_t3_len",   tr_n[3], 2);
        chk("zv_done",     32'(bus.scenario_state), 32'h07);
        chk("zv_shot",     32'(bus.shot_index), 1);
        end_run();
        chk("zv_idle", 32'(bus.scenario_state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
